// File: rtl/mem_store_buffer.sv
// Posted-store FIFO between the MEM stage and data memory: stores retire in one
// cycle, drain one word per cycle, and loads forward from the youngest pending match.
module mem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        StoreValid,
  input  logic [31:0] StoreAddr,
  input  logic [31:0] StoreData,
  output logic        Stall,
  input  logic [31:0] LoadAddr,
  output logic        LoadHit,
  output logic [31:0] LoadData,
  input  logic        DrainHold,
  output logic        MemWrite,
  output logic [31:0] MemAddr,
  output logic [31:0] MemWData,
  output logic        Empty,
  output logic        Full
);

  localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

  logic [29:0]      tag_q  [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             push, pop;

  // Full/Empty come only from count, so a wrapped pointer pair is never ambiguous.
  assign Empty    = (count_q == '0);
  assign Full     = (count_q == DEPTH_C);
  assign Stall    = StoreValid && Full;
  assign push     = StoreValid && !Full;
  assign MemWrite = !Empty && !DrainHold;
  assign pop      = MemWrite;
  assign MemAddr  = {tag_q[rd_ptr_q], 2'b00};
  assign MemWData = data_q[rd_ptr_q];

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (push && !pop)      count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage needs no reset; validity is defined by count alone.
  always_ff @(posedge Clk) begin
    if (push) begin
      tag_q[wr_ptr_q]  <= StoreAddr[31:2];
      data_q[wr_ptr_q] <= StoreData;
    end
  end

  // Walk oldest to youngest so the last match wins (youngest store forwards).
  always_comb begin
    LoadHit  = 1'b0;
    LoadData = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (((PTR_W+1)'(i) < count_q) &&
          (tag_q[rd_ptr_q + PTR_W'(i)] == LoadAddr[31:2])) begin
        LoadHit  = 1'b1;
        LoadData = data_q[rd_ptr_q + PTR_W'(i)];
      end
    end
  end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench: directed scenarios plus random traffic against a queue model.
module tb_mem_store_buffer;
  localparam int DEPTH = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        StoreValid, DrainHold;
  logic [31:0] StoreAddr, StoreData, LoadAddr;
  logic        Stall, LoadHit, MemWrite, Empty, Full;
  logic [31:0] LoadData, MemAddr, MemWData;

  mem_store_buffer #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .Clk(Clk), .Reset(Reset), .StoreValid(StoreValid), .StoreAddr(StoreAddr),
    .StoreData(StoreData), .Stall(Stall), .LoadAddr(LoadAddr), .LoadHit(LoadHit),
    .LoadData(LoadData), .DrainHold(DrainHold), .MemWrite(MemWrite),
    .MemAddr(MemAddr), .MemWData(MemWData), .Empty(Empty), .Full(Full)
  );

  always #5 Clk = ~Clk;

  typedef struct { logic [31:0] a; logic [31:0] d; } ent_t;
  ent_t q[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Compare every output against the pending-store queue.
  task automatic check_outs();
    logic        hit;
    logic [31:0] ld;
    logic        mw;
    hit = 1'b0;
    ld  = '0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i].a[31:2] == LoadAddr[31:2]) begin
        hit = 1'b1;
        ld  = q[i].d;
        break;
      end
    end
    mw = (q.size() != 0) && !DrainHold;
    chk("Empty",    32'(Empty),    32'(q.size() == 0));
    chk("Full",     32'(Full),     32'(q.size() == DEPTH));
    chk("Stall",    32'(Stall),    32'(StoreValid && q.size() == DEPTH));
    chk("MemWrite", 32'(MemWrite), 32'(mw));
    if (mw) begin
      chk("MemAddr",  MemAddr,  {q[0].a[31:2], 2'b00});
      chk("MemWData", MemWData, q[0].d);
    end
    chk("LoadHit",  32'(LoadHit), 32'(hit));
    chk("LoadData", LoadData, ld);
  endtask

  // One cycle: drive after negedge, check, then advance the model at posedge.
  task automatic step(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                      input logic [31:0] la, input logic dh);
    logic do_pop, do_push;
    @(negedge Clk);
    StoreValid = sv; StoreAddr = sa; StoreData = sd; LoadAddr = la; DrainHold = dh;
    #1;
    check_outs();
    do_pop  = (q.size() != 0) && !dh;
    do_push = sv && (q.size() < DEPTH);
    @(posedge Clk);
    if (do_pop)  void'(q.pop_front());
    if (do_push) q.push_back('{sa, sd});
  endtask

  task automatic idle(input int n, input logic dh);
    for (int i = 0; i < n; i++) step(1'b0, 32'h0, 32'h0, 32'hFFFF_FFF0, dh);
  endtask

  initial begin
    Reset = 1'b1; StoreValid = 1'b0; DrainHold = 1'b0;
    StoreAddr = '0; StoreData = '0; LoadAddr = '0;
    #1;
    check_outs();
    repeat (2) @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;

    // Single store, empty buffer: drains on the following cycle.
    step(1'b1, 32'h0000_0010, 32'hAAAA_0001, 32'h0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 32'h0000_0010, 1'b0);
    idle(1, 1'b0);

    // Fill under DrainHold, stall a fifth store, then release.
    for (int i = 0; i < 4; i++) step(1'b1, 32'(i * 4), 32'(i + 1), 32'h8, 1'b1);
    step(1'b1, 32'h100, 32'hDEAD_BEEF, 32'h4, 1'b1);
    idle(5, 1'b0);

    // Forwarding picks the youngest of two stores to the same word.
    step(1'b1, 32'h20, 32'h11, 32'h20, 1'b1);
    step(1'b1, 32'h20, 32'h22, 32'h23, 1'b1);
    step(1'b0, 32'h0, 32'h0, 32'h23, 1'b1);
    step(1'b0, 32'h0, 32'h0, 32'h24, 1'b1);
    step(1'b0, 32'h0, 32'h0, 32'h21, 1'b0);
    idle(2, 1'b0);

    // Steady push+pop at occupancy 2, wrapping the pointers.
    step(1'b1, 32'h200, 32'h5000, 32'h0, 1'b1);
    step(1'b1, 32'h204, 32'h5001, 32'h0, 1'b1);
    for (int i = 2; i < 12; i++)
      step(1'b1, 32'h200 + 32'(i * 4), 32'h5000 + 32'(i), 32'h200 + 32'(i * 4 - 4), 1'b0);
    idle(3, 1'b0);

    // Full with draining enabled: one stall cycle, then accepted.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h300 + 32'(i * 4), 32'h7000 + 32'(i), 32'h0, 1'b1);
    step(1'b1, 32'h340, 32'h7777, 32'h340, 1'b0);
    step(1'b1, 32'h340, 32'h7777, 32'h340, 1'b0);
    idle(6, 1'b0);

    // Random traffic over a small address pool to provoke hits and wraps.
    for (int i = 0; i < 400; i++) begin
      logic dh;
      dh = ((i / 20) % 2 == 1) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 4) == 0);
      step($urandom_range(0, 2) != 0, {26'h0, 4'($urandom), 2'($urandom)}, $urandom,
           {26'h0, 4'($urandom), 2'($urandom)}, dh);
    end

    // Asynchronous reset mid-drain with three entries pending.
    idle(6, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h400 + 32'(i * 4), 32'h9000 + 32'(i), 32'h0, 1'b1);
    step(1'b0, 32'h0, 32'h0, 32'h404, 1'b0);
    @(negedge Clk);
    StoreValid = 1'b1; StoreAddr = 32'h500; LoadAddr = 32'h404; DrainHold = 1'b0;
    #2 Reset = 1'b1;
    #1;
    q.delete();
    check_outs();
    StoreValid = 1'b0;
    @(posedge Clk);
    @(negedge Clk) Reset = 1'b0;
    step(1'b0, 32'h0, 32'h0, 32'h408, 1'b0);
    idle(3, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Word-granular posted-store FIFO between the pipeline MEM stage and the data memory.
- Stores retire from MEM in one cycle into the buffer, then drain one word per cycle into the data memory's Addr/WData/MemWrite write port.
- Loads in MEM probe the buffer; the youngest pending store to the same word is forwarded, which hides not-yet-drained writes.

Parameters:
- DEPTH, 4, number of entries; power of two, 2..16.
- PTR_W, 2, log2(DEPTH); sets pointer width (count is PTR_W+1 bits).

Ports:
- Clk  input  1  rising-edge clock.
- Reset  input  1  asynchronous, active-high reset.
- StoreValid  input  1  MEM stage presents a word store this cycle.
- StoreAddr  input  32  byte address of store; bits [1:0] ignored.
- StoreData  input  32  store data word.
- Stall  output  1  store cannot be accepted; MEM stage must hold.
- LoadAddr  input  32  byte address of MEM-stage load probe; bits [1:0] ignored.
- LoadHit  output  1  a buffered entry matches LoadAddr[31:2].
- LoadData  output  32  data of youngest matching entry; 0 when no hit.
- DrainHold  input  1  inhibit draining this cycle.
- MemWrite  output  1  write strobe to data memory.
- MemAddr  output  32  write address to data memory, {tag, 2'b00}.
- MemWData  output  32  write data to data memory.
- Empty  output  1  count == 0.
- Full  output  1  count == DEPTH.

Behaviour:
- Storage: DEPTH entries of {tag[29:0], data[31:0]}, circular; head pointer rd_ptr, tail pointer wr_ptr, and count, all PTR_W/PTR_W+1 bits.
- Reset (async, any time, including mid-drain):
  - rd_ptr = wr_ptr = count = 0.
  - Outputs immediately: MemWrite=0, Empty=1, Full=0, LoadHit=0, LoadData=0, Stall=0.
  - Entry contents are don't-care.
  - Pending stores are discarded, not flushed.
- Push: when StoreValid && count<DEPTH, entry[wr_ptr] <= {StoreAddr[31:2], StoreData} at the clock edge, and wr_ptr increments mod DEPTH.
- Stall = StoreValid && (count==DEPTH), combinational. A stalled store is not written.
- No push-while-full even if a pop occurs in the same cycle.
- Drain/pop:
  - MemWrite = !Empty && !DrainHold, combinational from registered state.
  - MemAddr = {entry[rd_ptr].tag, 2'b00}; MemWData = entry[rd_ptr].data.
  - On a clock edge with MemWrite=1, rd_ptr increments mod DEPTH.
  - While MemWrite=0, MemAddr and MemWData are held at the head entry value and are don't-care.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: unchanged.
- Latency:
  - A store accepted in cycle N appears on MemWrite no earlier than cycle N+1, when it is at the head.
  - An empty buffer gives exactly 1 cycle of latency.
- Ordering: strict FIFO; stores to the same word are not coalesced, and each store drains separately in program order.
- Load forwarding (combinational):
  - Compare LoadAddr[31:2] against every valid entry tag.
  - An entry is valid if it lies within count entries from rd_ptr.
  - On multiple matches, select the youngest, i.e. the one closest to wr_ptr.
  - The head entry being drained this cycle still counts as valid for the probe.
  - The store being pushed this cycle is not visible until the next cycle.
- Wrap-around: pointers wrap mod DEPTH. Full and Empty derive only from count, never from pointer equality.
- Full/Empty:
  - Full=1 exactly when count==DEPTH.
  - Empty=1 exactly when count==0.
  - Both are registered-state functions with no glitch dependence on inputs.

Test Plan:
- Reset with StoreValid=0 -> Empty=1, MemWrite=0, LoadHit=0; assert Reset mid-drain with 3 entries -> next cycle MemWrite=0, Empty=1, no further writes.
- Push 0x0000_0010/0xAAAA_0001 in cycle 0, DrainHold=0 -> cycle 1: MemWrite=1, MemAddr=0x10, MemWData=0xAAAA_0001; cycle 2: Empty=1.
- DrainHold=1, push 4 stores (addr 0x0,0x4,0x8,0xC, data 1..4) -> Full=1; 5th StoreValid -> Stall=1 and count stays 4; release DrainHold -> writes 1,2,3,4 in consecutive cycles.
- DrainHold=1, push 0x20/0x11 then 0x20/0x22; probe LoadAddr=0x23 -> LoadHit=1, LoadData=0x22; probe 0x24 -> LoadHit=0, LoadData=0.
- Simultaneous push and pop at count=2 for 10 cycles with incrementing addresses -> count stays 2, pointers wrap past DEPTH, drained data matches push order exactly.
- Full with DrainHold=0 and StoreValid=1 -> Stall=1 for one cycle, head pops, next cycle Stall=0 and store accepted; no entry lost or duplicated.
